zapper_sense: RTL
=================

Name: zapper_sense

Overview:
- Light-gun front end: the producer side of the trigger/detect pair consumed by the game pattern generator.
- Synchronises and debounces the raw trigger switch and runs a per-frame shot sequencer (IDLE→BLACK→WHITE→HOLD) locked to the frame tick.
- Counts photodiode-lit active pixels in each phase and asserts detect only if the black frame was dark and the white frame was bright (rejects aiming at a lamp).
- Sits between the gun connector pins and the game logic, on the pixel clock.

Parameters:
- DEBOUNCE_CYCLES, 250000, stable-sample cycles before debounced trigger changes (about 10 ms at 25 MHz).
- COUNT_W, 19, width of light counters (640*480 fits).
- DARK_MAX, 16, max lit pixels tolerated during the BLACK frame.
- LIGHT_MIN, 200, lit pixels needed during the WHITE frame to assert detect.
- LIGHT_ACTIVE_LOW, 1, 1 means light_raw=0 indicates light seen.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse at the frame boundary, from VGA timing
- valid  in  1  active-video qualifier
- enable  in  1  game is IN_GAME; sequencer may leave IDLE only when high
- trigger_raw  in  1  raw switch, active high, asynchronous
- light_raw  in  1  raw photodiode comparator, asynchronous
- trigger  out  1  debounced trigger level
- detect  out  1  hit result, valid from WHITE until the first tick in HOLD
- shot_active  out  1  high whenever state is not IDLE
- last_light  out  COUNT_W  WHITE-frame lit-pixel count latched at WHITE exit

Behaviour:
- Reset (rst=0, async): state=IDLE; trigger=0, detect=0, shot_active=0, last_light=0; both counters, dark_ok and debounce counter cleared; synchroniser flops=0.
- Synchronisers: trigger_raw and light_raw each pass through 2 flops. lit = sync_light XOR LIGHT_ACTIVE_LOW. Input-to-use latency is 2 cycles.
- Debounce: counter resets whenever sync_trig equals trigger. Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, trigger <= sync_trig and the counter clears. Bounces shorter than DEBOUNCE_CYCLES never propagate.
- Light counter: increments when valid && lit && !frame_tick. It saturates at all-ones and never wraps. It clears on every frame_tick; the tick-cycle sample is discarded.
- State transitions are evaluated only on frame_tick cycles:
  - IDLE: if enable && trigger → BLACK.
  - BLACK: → WHITE; dark_ok <= (count <= DARK_MAX).
  - WHITE: → HOLD; last_light <= count.
  - HOLD: detect <= 0; if !trigger → IDLE, else stay HOLD.
- detect set: in WHITE, on the cycle count first reaches >= LIGHT_MIN with dark_ok=1, register detect <= 1 (1-cycle latency). detect is never set outside WHITE.
- detect is high on the frame_tick that ends WHITE, so the game samples it at that boundary. It clears at the next frame_tick in HOLD.
- enable deasserted mid-sequence: the sequence completes normally. Only IDLE exit is gated.
- Reset mid-sequence: immediate return to IDLE with all outputs 0.
- frame_tick arriving while trigger changes the same cycle: the new debounced value is used from the next tick.
- Trigger held continuously: exactly one shot. Re-fire requires release through HOLD→IDLE, then a new press.
- shot_active = (state != IDLE), registered with the state.

Test Plan:
- Bench parameters: DEBOUNCE_CYCLES=4, LIGHT_MIN=10, DARK_MAX=2, frames of 100 valid pixels, LIGHT_ACTIVE_LOW=1.
- Debounce: toggle trigger_raw high for 3 cycles then low → trigger stays 0. Hold high 8 cycles → trigger=1 by cycle 6 (2 sync + 4 debounce).
- Hit: trigger=1, enable=1, tick → BLACK, light_raw=1 all frame. Tick → WHITE, light_raw=0 for 20 valid pixels → detect=1 after the 10th lit pixel +1 cycle, last_light=20 at next tick, detect=0 at the following tick.
- Lamp rejection: same as Hit but 5 lit pixels in BLACK → dark_ok=0, detect stays 0, last_light still latched.
- Miss: 9 lit pixels in WHITE → detect=0. State reaches HOLD, stays while trigger=1, returns to IDLE on the first tick after release. shot_active falls with the state.
- Gating/reset: enable=0 with trigger=1 over 3 ticks → remains IDLE. Then enable=1 and assert rst=0 mid-WHITE with detect=1 → state IDLE, detect=0, last_light=0 immediately. Count saturation: force 2^19+5 lit pixels in a frame → count holds all-ones.

Source files
------------

// File: rtl/zapper_sense_if.sv
// zapper_sense_if: bundle between the light-gun front end and the game logic.
//
// Signals (direction as seen from the zapper_sense / master side):
//   frame_tick  in   one-cycle pulse at each frame boundary (VGA timing)
//   valid       in   active-video qualifier for the current pixel
//   enable      in   game is in play; the shot sequencer may leave IDLE only when high
//   trigger_raw in   raw trigger switch, active high, asynchronous
//   light_raw   in   raw photodiode comparator, asynchronous
//   trigger     out  debounced trigger level
//   detect      out  hit result, valid from WHITE until the first tick in HOLD
//   shot_active out  high whenever the sequencer is not IDLE
//   last_light  out  WHITE-frame lit-pixel count latched at WHITE exit
//   state_dbg   out  sequencer state (0 IDLE, 1 BLACK, 2 WHITE, 3 HOLD)
//
// Transfer semantics: there is no back-pressure. A pixel is consumed on every
// clock where valid=1 and frame_tick=0. The game samples detect on the
// frame_tick cycle that ends the WHITE frame. All outputs are registered.
interface zapper_sense_if #(
  parameter int COUNT_W = 19
);
  logic               frame_tick;
  logic               valid;
  logic               enable;
  logic               trigger_raw;
  logic               light_raw;
  logic               trigger;
  logic               detect;
  logic               shot_active;
  logic [COUNT_W-1:0] last_light;
  logic [1:0]         state_dbg;

  modport master (
    input  frame_tick, valid, enable, trigger_raw, light_raw,
    output trigger, detect, shot_active, last_light, state_dbg
  );

  modport slave (
    output frame_tick, valid, enable, trigger_raw, light_raw,
    input  trigger, detect, shot_active, last_light, state_dbg
  );
endinterface

// File: rtl/zapper_sense.sv
// zapper_sense: light-gun front end on the pixel clock.
//
// Synchronises the trigger switch and photodiode, debounces the trigger, and
// runs a frame-locked shot sequencer IDLE -> BLACK -> WHITE -> HOLD. A hit is
// reported only when the BLACK frame stayed dark and the WHITE frame was
// bright, which rejects a gun pointed at a lamp.
//
// Ports:
//   clk  pixel clock
//   rst  asynchronous, active-low reset
//   zs   zapper_sense_if.master (frame_tick, valid, enable, trigger_raw,
//        light_raw in; trigger, detect, shot_active, last_light, state_dbg out)
module zapper_sense #(
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int COUNT_W          = 19,
  parameter int DARK_MAX         = 16,
  parameter int LIGHT_MIN        = 200,
  parameter int LIGHT_ACTIVE_LOW = 1
) (
  input  logic           clk,
  input  logic           rst,
  zapper_sense_if.master zs
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0]    DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [COUNT_W-1:0] DARK_MAX_C  = COUNT_W'(DARK_MAX);
  localparam logic [COUNT_W-1:0] LIGHT_MIN_C = COUNT_W'(LIGHT_MIN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic               trig_s1, trig_s2, light_s1, light_s2;
  logic               lit;
  logic [DB_W-1:0]    db_cnt;
  logic               trigger_q;
  logic [COUNT_W-1:0] light_cnt;
  logic               dark_ok;
  logic               detect_q;
  logic               shot_active_q;
  logic [COUNT_W-1:0] last_light_q;

  // Two-flop synchronisers for both asynchronous pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_s1  <= 1'b0;
      trig_s2  <= 1'b0;
      light_s1 <= 1'b0;
      light_s2 <= 1'b0;
    end else begin
      trig_s1  <= zs.trigger_raw;
      trig_s2  <= trig_s1;
      light_s1 <= zs.light_raw;
      light_s2 <= light_s1;
    end
  end

  assign lit = (LIGHT_ACTIVE_LOW != 0) ? ~light_s2 : light_s2;

  // Debounce: the counter only runs while the synchronised input disagrees
  // with the published level, so any disagreement shorter than
  // DEBOUNCE_CYCLES is discarded.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt    <= '0;
      trigger_q <= 1'b0;
    end else if (trig_s2 == trigger_q) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      trigger_q <= trig_s2;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Per-frame lit-pixel counter. The tick-cycle sample belongs to neither
  // frame and is dropped; the counter saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_cnt <= '0;
    end else if (zs.frame_tick) begin
      light_cnt <= '0;
    end else if (zs.valid && lit && !(&light_cnt)) begin
      light_cnt <= light_cnt + 1'b1;
    end
  end

  // Sequencer state register; shot_active is registered alongside it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      shot_active_q <= 1'b0;
    end else begin
      state         <= state_next;
      shot_active_q <= (state_next != IDLE);
    end
  end

  // Transitions happen only at frame boundaries. enable gates only the IDLE
  // exit, so a shot in progress always runs to completion.
  always_comb begin
    state_next = state;
    if (zs.frame_tick) begin
      case (state)
        IDLE:    if (zs.enable && trigger_q) state_next = BLACK;
        BLACK:   state_next = WHITE;
        WHITE:   state_next = HOLD;
        HOLD:    if (!trigger_q) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Shot datapath. detect rises inside WHITE once enough light is seen after
  // a dark BLACK frame, stays up across the tick ending WHITE so the game
  // can sample it, and drops at the first tick in HOLD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dark_ok      <= 1'b0;
      last_light_q <= '0;
      detect_q     <= 1'b0;
    end else begin
      if (zs.frame_tick && state == BLACK) dark_ok      <= (light_cnt <= DARK_MAX_C);
      if (zs.frame_tick && state == WHITE) last_light_q <= light_cnt;
      if (zs.frame_tick && state == HOLD)  detect_q     <= 1'b0;
      if (state == WHITE && dark_ok && light_cnt >= LIGHT_MIN_C) detect_q <= 1'b1;
    end
  end

  assign zs.trigger     = trigger_q;
  assign zs.detect      = detect_q;
  assign zs.shot_active = shot_active_q;
  assign zs.last_light  = last_light_q;
  assign zs.state_dbg   = state;

endmodule
